// File: rtl/spi_sched_pkg.sv
// Shared definitions for the round-robin SPI read scheduler: FSM state codes,
// default timing constants and a constant-evaluable clog2 helper.
package spi_sched_pkg;

   // FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_SHIFT = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Default configuration
   localparam int DEF_N_REQ      = 2;
   localparam int DEF_FRAME_BITS = 16;
   localparam int DEF_CLK_DIV    = 4;
   localparam int DEF_CS_SETUP   = 2;
   localparam int DEF_CS_HOLD    = 2;

   // Ceiling log2; clog2(1) = 0
   function automatic int clog2(input int value);
      int r;
      int p;
      r = 0;
      p = 1;
      while (p < value) begin
         p = p * 2;
         r = r + 1;
      end
      return r;
   endfunction

   // Counter width that is never zero, even when the count range is 1
   function automatic int cnt_w(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/spi_rr_scheduler_if.sv
// Requester-side handshake plus the shared SPI pins of the scheduler.
// master: the scheduler itself; slave: requesters/devices (or a bench).
interface spi_rr_scheduler_if #(
   parameter int N_REQ      = spi_sched_pkg::DEF_N_REQ,
   parameter int FRAME_BITS = spi_sched_pkg::DEF_FRAME_BITS
);
   logic [N_REQ-1:0]      req;
   logic                  sdo;
   logic                  scl;
   logic [N_REQ-1:0]      cs;
   logic [FRAME_BITS-1:0] data;
   logic [N_REQ-1:0]      done;
   logic                  busy;

   modport master (
      input  req, sdo,
      output scl, cs, data, done, busy
   );

   modport slave (
      output req, sdo,
      input  scl, cs, data, done, busy
   );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin winner select: scans upward from ptr_i+1 modulo
// N_REQ and returns the first requester found as one-hot grant and index.
module spi_rr_arbiter
   import spi_sched_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int IDX_W = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             vld_o
);

   // Walk the scan order backwards so the nearest requester after ptr_i is the last to write
   always_comb begin : scan
      int               cand;
      logic [IDX_W-1:0] cidx;
      cand  = 0;
      cidx  = '0;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      for (int i = N_REQ; i >= 1; i--) begin
         cand = (int'(ptr_i) + i) % N_REQ;
         cidx = IDX_W'(cand);
         if (req_i[cidx]) begin
            gnt_o       = '0;
            gnt_o[cidx] = 1'b1;
            idx_o       = cidx;
            vld_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_rr_scheduler.sv
// Round-robin scheduler sharing one read-only SPI bus among N_REQ requesters.
// One FRAME_BITS read frame per grant; the word comes back with a done pulse.
// All outputs come straight from registers; reset aborts a frame at once.
module spi_rr_scheduler
   import spi_sched_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int CS_SETUP   = DEF_CS_SETUP,
   parameter int CS_HOLD    = DEF_CS_HOLD
) (
   input logic                clk_i,
   input logic                rst_ni,
   spi_rr_scheduler_if.master bus
);

   localparam int IDX_W = clog2(N_REQ);
   localparam int DIV_W = cnt_w(CLK_DIV);
   localparam int BIT_W = clog2(FRAME_BITS + 1);
   localparam int TMR_W = cnt_w((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

   logic [N_REQ-1:0]      req;
   logic                  sdo;

   logic [N_REQ-1:0]      arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_vld;

   state_t                state_q,   state_d;
   logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]      ptr_q,     ptr_d;
   logic [TMR_W-1:0]      tmr_q,     tmr_d;
   logic [DIV_W-1:0]      div_q,     div_d;
   logic                  ph_q,      ph_d;
   logic [BIT_W-1:0]      bit_q,     bit_d;
   logic [FRAME_BITS-1:0] shreg_q,   shreg_d;
   logic                  scl_q,     scl_d;
   logic [N_REQ-1:0]      cs_q,      cs_d;
   logic [FRAME_BITS-1:0] data_q,    data_d;
   logic [N_REQ-1:0]      done_q,    done_d;
   logic                  busy_q,    busy_d;

   assign req      = bus.req;
   assign sdo      = bus.sdo;
   assign bus.scl  = scl_q;
   assign bus.cs   = cs_q;
   assign bus.data = data_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;

   spi_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   // Next-state logic for the frame FSM, scl divider, bit counter and output registers
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      tmr_d     = tmr_q;
      div_d     = div_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      scl_d     = scl_q;
      cs_d      = cs_q;
      data_d    = data_q;
      done_d    = '0;

      case (state_q)
         ST_IDLE: begin
            // req is only looked at here, so late changes wait for the next IDLE
            if (arb_vld) begin
               state_d   = ST_SETUP;
               gnt_idx_d = arb_idx;
               cs_d      = ~arb_gnt;
               tmr_d     = '0;
            end
         end

         ST_SETUP: begin
            if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
               state_d = ST_SHIFT;
               scl_d   = 1'b0;
               div_d   = '0;
               ph_d    = 1'b0;
               bit_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         ST_SHIFT: begin
            // ph_q=0: low half-period, ph_q=1: high half-period of the current bit
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
               div_d = '0;
               if (!ph_q) begin
                  scl_d   = 1'b1;
                  ph_d    = 1'b1;
                  shreg_d = {shreg_q[FRAME_BITS-2:0], sdo};
                  bit_d   = bit_q + BIT_W'(1);
               end else if (bit_q == BIT_W'(FRAME_BITS)) begin
                  state_d = ST_HOLD;
                  tmr_d   = '0;
               end else begin
                  scl_d = 1'b0;
                  ph_d  = 1'b0;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         ST_HOLD: begin
            if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
               state_d           = ST_DONE;
               cs_d              = '1;
               data_d            = shreg_q;
               done_d[gnt_idx_q] = 1'b1;
               ptr_d             = gnt_idx_q;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cs_d    = '1;
            scl_d   = 1'b1;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; async reset drops cs/scl high immediately
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         gnt_idx_q <= '0;
         ptr_q     <= IDX_W'(N_REQ - 1);
         tmr_q     <= '0;
         div_q     <= '0;
         ph_q      <= 1'b0;
         bit_q     <= '0;
         shreg_q   <= '0;
         scl_q     <= 1'b1;
         cs_q      <= '1;
         data_q    <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
         tmr_q     <= tmr_d;
         div_q     <= div_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         scl_q     <= scl_d;
         cs_q      <= cs_d;
         data_q    <= data_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

endmodule
